// File: rtl/ntt_pkg.sv
// Shared constants and types for the 256-point NTT/INTT sequencer (q = 8380417).
package ntt_pkg;

  localparam logic [22:0] Q    = 23'd8380417;
  localparam int unsigned N    = 256;
  localparam int unsigned LOGN = 8;
  localparam int unsigned NBF  = 128;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    DRAIN = ST_DRAIN,
    FLUSH = ST_FLUSH,
    DONE  = ST_DONE
  } ntt_state_t;

  typedef logic [7:0] coef_addr_t;
  typedef logic [7:0] tw_idx_t;
  typedef logic [2:0] layer_t;
  typedef logic [6:0] bf_idx_t;

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-depth shift register with synchronous clear; depth 0 degenerates to a wire.
module ntt_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q_o = d_i;
    end else begin : g_pipe
      logic [W-1:0] pipe_q [DEPTH];
      logic [W-1:0] pipe_d [DEPTH];

      always_comb begin
        pipe_d[0] = d_i;
        for (int i = 1; i < DEPTH; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_d[i];
          end
        end
      end

      assign q_o = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/ntt_sched.sv
// In-place 256-point NTT/INTT sequencer: read addresses, twiddle index and butterfly selects,
// with write-back addresses as delayed copies of the read side.
//
// state | meaning
// IDLE  | waiting for start_i
// ISSUE | one coefficient-pair read per cycle for layer l
// DRAIN | D idle cycles so layer l writes land before layer l+1 reads
// FLUSH | D cycles until the final write has been issued
// DONE  | done_o pulse, then back to IDLE
module ntt_sched
  import ntt_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       inv_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       rd_en_o,
  output logic [7:0] rd_addr_a_o,
  output logic [7:0] rd_addr_b_o,
  output logic [7:0] tw_idx_o,
  output logic       sel_butterfly_o,
  output logic       sel_red_o,
  output logic       wr_en_o,
  output logic [7:0] wr_addr_a_o,
  output logic [7:0] wr_addr_b_o
);

  localparam int D  = RD_LAT + BF_LAT;
  localparam int CW = $clog2(D + 1);

  ntt_state_t    state_q, state_d;
  layer_t        l_q, l_d;
  bf_idx_t       bf_q, bf_d;
  logic          inv_q, inv_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    bf_d    = bf_q;
    inv_d   = inv_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ISSUE;
          l_d     = '0;
          bf_d    = '0;
          inv_d   = inv_i;
        end
      end
      ISSUE: begin
        if (bf_q == bf_idx_t'(NBF - 1)) begin
          cnt_d   = CW'(D - 1);
          state_d = (l_q == layer_t'(LOGN - 1)) ? FLUSH : DRAIN;
        end else begin
          bf_d = bf_q + 7'd1;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ISSUE;
          l_d     = l_q + 3'd1;
          bf_d    = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from next-state values so they leave registers aligned with the FSM.
  logic       rd_en_d, busy_d, done_d, sel_bf_iss_d, sel_red_iss_d;
  logic [2:0] k;
  logic [7:0] bf_ext, span, grp, off, addr_a, addr_b, tw;
  logic [7:0] rd_addr_a_d, rd_addr_b_d, tw_idx_d;

  always_comb begin
    rd_en_d = (state_d == ISSUE);
    busy_d  = (state_d == ISSUE) || (state_d == DRAIN) || (state_d == FLUSH);
    done_d  = (state_d == DONE);

    // The pair address is bf with a zero inserted at bit k; its partner has that bit set.
    k      = inv_d ? l_d : (3'd7 - l_d);
    bf_ext = {1'b0, bf_d};
    span   = 8'd1 << k;
    grp    = bf_ext >> k;
    off    = bf_ext & (span - 8'd1);
    addr_a = (grp << ({1'b0, k} + 4'd1)) | off;
    addr_b = addr_a | span;
    tw     = inv_d ? ((8'hff >> l_d) - grp) : ((8'd1 << l_d) + grp);

    rd_addr_a_d   = rd_en_d ? addr_a : '0;
    rd_addr_b_d   = rd_en_d ? addr_b : '0;
    tw_idx_d      = rd_en_d ? tw : '0;
    sel_bf_iss_d  = rd_en_d & inv_d;
    sel_red_iss_d = rd_en_d & (l_d == layer_t'(LOGN - 1));
  end

  logic       rd_en_q, busy_q, done_q, sel_bf_iss_q, sel_red_iss_q;
  logic [7:0] rd_addr_a_q, rd_addr_b_q, tw_idx_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      l_q           <= '0;
      bf_q          <= '0;
      inv_q         <= 1'b0;
      cnt_q         <= '0;
      rd_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      sel_bf_iss_q  <= 1'b0;
      sel_red_iss_q <= 1'b0;
      rd_addr_a_q   <= '0;
      rd_addr_b_q   <= '0;
      tw_idx_q      <= '0;
    end else begin
      state_q       <= state_d;
      l_q           <= l_d;
      bf_q          <= bf_d;
      inv_q         <= inv_d;
      cnt_q         <= cnt_d;
      rd_en_q       <= rd_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      sel_bf_iss_q  <= sel_bf_iss_d;
      sel_red_iss_q <= sel_red_iss_d;
      rd_addr_a_q   <= rd_addr_a_d;
      rd_addr_b_q   <= rd_addr_b_d;
      tw_idx_q      <= tw_idx_d;
    end
  end

  // Selects meet the data at the butterfly input; writes meet its output.
  logic [1:0]  sel_bus;
  logic [16:0] wr_bus;

  ntt_delay_line #(.W(2), .DEPTH(RD_LAT)) u_sel_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   ({sel_bf_iss_q, sel_red_iss_q}),
    .q_o   (sel_bus)
  );

  ntt_delay_line #(.W(17), .DEPTH(D)) u_wr_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   ({rd_en_q, rd_addr_a_q, rd_addr_b_q}),
    .q_o   (wr_bus)
  );

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign rd_en_o         = rd_en_q;
  assign rd_addr_a_o     = rd_addr_a_q;
  assign rd_addr_b_o     = rd_addr_b_q;
  assign tw_idx_o        = tw_idx_q;
  assign sel_butterfly_o = sel_bus[1];
  assign sel_red_o       = sel_bus[0];
  assign wr_en_o         = wr_bus[16];
  assign wr_addr_a_o     = wr_bus[15:8];
  assign wr_addr_b_o     = wr_bus[7:0];

endmodule

// File: tb/tb_ntt_sched.sv
// Bench for ntt_sched: a default instance (D=1) and a deep-pipeline instance (D=3) share stimulus
// and are checked every cycle against a schedule model built from the layer/butterfly formulas.
module tb_ntt_sched;

  localparam int D_A = 1, RDL_A = 1;
  localparam int D_H = 3, RDL_H = 1;
  localparam int NEVER = -100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i, start_i, inv_i;
  logic busy_a, done_a, rd_en_a, wr_en_a, sbf_a, sred_a;
  logic [7:0] ra_a, rb_a, tw_a, wa_a, wb_a;
  logic busy_h, done_h, rd_en_h, wr_en_h, sbf_h, sred_h;
  logic [7:0] ra_h, rb_h, tw_h, wa_h, wb_h;

  ntt_sched dut_a (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .inv_i(inv_i),
    .busy_o(busy_a), .done_o(done_a), .rd_en_o(rd_en_a),
    .rd_addr_a_o(ra_a), .rd_addr_b_o(rb_a), .tw_idx_o(tw_a),
    .sel_butterfly_o(sbf_a), .sel_red_o(sred_a),
    .wr_en_o(wr_en_a), .wr_addr_a_o(wa_a), .wr_addr_b_o(wb_a)
  );

  ntt_sched #(.RD_LAT(1), .BF_LAT(2)) dut_h (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .inv_i(inv_i),
    .busy_o(busy_h), .done_o(done_h), .rd_en_o(rd_en_h),
    .rd_addr_a_o(ra_h), .rd_addr_b_o(rb_h), .tw_idx_o(tw_h),
    .sel_butterfly_o(sbf_h), .sel_red_o(sred_h),
    .wr_en_o(wr_en_h), .wr_addr_a_o(wa_h), .wr_addr_b_o(wb_h)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] tw;
    logic       wr_en;
    logic [7:0] wa;
    logic [7:0] wb;
    logic       sbf;
    logic       sred;
  } obs_t;

  int   n_assert = 0, n_fail = 0, cyc = 0;
  int   s_a = NEVER, s_h = NEVER, rel_a, rel_h;
  bit   inv_ma, inv_mh;
  obs_t raw_a, raw_h, got_a, got_h, exp_a, exp_h;

  function automatic int last_wr(int d);
    return 128 + 7 * (128 + d) + d;
  endfunction

  // Relative cycle t (start sampled at t=0) -> is a read issued, and for which layer/butterfly.
  function automatic bit issue_at(int t, int d, output int l, output int bf);
    l = 0; bf = 0;
    if (t < 1) return 1'b0;
    l  = (t - 1) / (128 + d);
    bf = (t - 1) % (128 + d);
    return (l < 8) && (bf < 128);
  endfunction

  function automatic void addr_model(input bit inv, input int l, input int bf,
                                     output int a, output int b, output int tw);
    int len, g, off;
    len = inv ? (1 << l) : (128 >> l);
    g   = inv ? (bf >> l) : (bf >> (7 - l));
    off = bf & (len - 1);
    a   = 2 * g * len + off;
    b   = a + len;
    tw  = inv ? ((256 >> l) - 1 - g) : ((1 << l) + g);
  endfunction

  function automatic obs_t want(int rel, bit inv, int d, int rdl);
    obs_t e;
    int l, bf, a, b, tw;
    e = '0;
    e.busy = (rel >= 1) && (rel <= last_wr(d));
    e.done = (rel == last_wr(d) + 1);
    if (issue_at(rel, d, l, bf)) begin
      addr_model(inv, l, bf, a, b, tw);
      e.rd_en = 1'b1; e.ra = 8'(a); e.rb = 8'(b); e.tw = 8'(tw);
    end
    if (issue_at(rel - d, d, l, bf)) begin
      addr_model(inv, l, bf, a, b, tw);
      e.wr_en = 1'b1; e.wa = 8'(a); e.wb = 8'(b);
    end
    if (issue_at(rel - rdl, d, l, bf)) begin
      e.sbf  = inv;
      e.sred = (l == 7);
    end
    return e;
  endfunction

  // Addresses are only meaningful while their strobe is high.
  function automatic obs_t mask(obs_t o);
    obs_t m;
    m = o;
    if (o.rd_en !== 1'b1) begin m.ra = '0; m.rb = '0; m.tw = '0; end
    if (o.wr_en !== 1'b1) begin m.wa = '0; m.wb = '0; end
    return m;
  endfunction

  // Drive inputs for the current cycle, track which starts each instance accepts, advance one cycle.
  task automatic tick(input bit st, input bit iv, input bit rs);
    start_i = st; inv_i = iv; rst_i = rs;
    if (rs) begin
      s_a = NEVER; s_h = NEVER;
    end else if (st) begin
      if (cyc > s_a + last_wr(D_A) + 1) begin s_a = cyc; inv_ma = iv; end
      if (cyc > s_h + last_wr(D_H) + 1) begin s_h = cyc; inv_mh = iv; end
    end
    @(negedge clk);
    cyc++;
    rel_a = cyc - s_a;
    rel_h = cyc - s_h;
    raw_a = {busy_a, done_a, rd_en_a, ra_a, rb_a, tw_a, wr_en_a, wa_a, wb_a, sbf_a, sred_a};
    raw_h = {busy_h, done_h, rd_en_h, ra_h, rb_h, tw_h, wr_en_h, wa_h, wb_h, sbf_h, sred_h};
    got_a = mask(raw_a);
    got_h = mask(raw_h);
    exp_a = want(rel_a, inv_ma, D_A, RDL_A);
    exp_h = want(rel_h, inv_mh, D_H, RDL_H);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
    n_assert++;
    if (raw_a !== '0) begin n_fail++; $display("FAIL reset_a got=%h want=0", raw_a); end
    n_assert++;
    if (raw_h !== '0) begin n_fail++; $display("FAIL reset_h got=%h want=0", raw_h); end
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
    n_assert++;
    if (raw_a !== '0 || raw_h !== '0) begin
      n_fail++; $display("FAIL idle_zero got_a=%h got_h=%h want=0", raw_a, raw_h);
    end
  endtask

  task automatic test_forward();
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 1052; i++) begin
      n_assert++;
      if (got_a !== exp_a) begin n_fail++; $display("FAIL fwd_a rel=%0d got=%h want=%h", rel_a, got_a, exp_a); end
      n_assert++;
      if (got_h !== exp_h) begin n_fail++; $display("FAIL fwd_h rel=%0d got=%h want=%h", rel_h, got_h, exp_h); end
      if (rel_a == 1 || rel_a == 2 || rel_a == 904 || rel_a == 1031) begin
        n_assert++;
        if (rd_en_a !== 1'b1 || {ra_a, rb_a, tw_a} !==
            ((rel_a == 1) ? {8'd0, 8'd128, 8'd1} : (rel_a == 2) ? {8'd1, 8'd129, 8'd1} :
             (rel_a == 904) ? {8'd0, 8'd1, 8'd128} : {8'd254, 8'd255, 8'd255})) begin
          n_fail++; $display("FAIL fwd_spot rel=%0d got=%0d,%0d,%0d en=%b", rel_a, ra_a, rb_a, tw_a, rd_en_a);
        end
      end
      if (rel_a == 1032 || rel_a == 1033) begin
        n_assert++;
        if ({done_a, wr_en_a, busy_a} !== ((rel_a == 1032) ? 3'b011 : 3'b100)) begin
          n_fail++; $display("FAIL fwd_end rel=%0d got done,wr,busy=%b%b%b", rel_a, done_a, wr_en_a, busy_a);
        end
      end
      tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_inverse();
    int n_wr;
    n_wr = 0;
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 1052; i++) begin
      n_assert++;
      if (got_a !== exp_a) begin n_fail++; $display("FAIL inv_a rel=%0d got=%h want=%h", rel_a, got_a, exp_a); end
      n_assert++;
      if (got_h !== exp_h) begin n_fail++; $display("FAIL inv_h rel=%0d got=%h want=%h", rel_h, got_h, exp_h); end
      if (rel_a == 1 || rel_a == 904 || rel_a == 1031) begin
        n_assert++;
        if (rd_en_a !== 1'b1 || {ra_a, rb_a, tw_a} !==
            ((rel_a == 1) ? {8'd0, 8'd1, 8'd255} : (rel_a == 904) ? {8'd0, 8'd128, 8'd1} :
             {8'd127, 8'd255, 8'd1})) begin
          n_fail++; $display("FAIL inv_spot rel=%0d got=%0d,%0d,%0d en=%b", rel_a, ra_a, rb_a, tw_a, rd_en_a);
        end
      end
      if (wr_en_a === 1'b1) n_wr++;
      tick(1'b0, 1'b1, 1'b0);
    end
    n_assert++;
    if (n_wr != 1024) begin n_fail++; $display("FAIL inv_wr_count got=%0d want=1024", n_wr); end
  endtask

  task automatic test_hazard();
    bit iv;
    int red_a, red_h;
    iv = ($urandom_range(0, 1) != 0);
    red_a = 0; red_h = 0;
    tick(1'b1, iv, 1'b0);
    for (int i = 0; i < 1052; i++) begin
      n_assert++;
      if (got_a !== exp_a) begin n_fail++; $display("FAIL haz_a rel=%0d got=%h want=%h", rel_a, got_a, exp_a); end
      n_assert++;
      if (got_h !== exp_h) begin n_fail++; $display("FAIL haz_h rel=%0d got=%h want=%h", rel_h, got_h, exp_h); end
      if (rel_h >= 129 && rel_h <= 131) begin
        n_assert++;
        if (rd_en_h !== 1'b0) begin n_fail++; $display("FAIL haz_gap rel=%0d got rd_en=%b want 0", rel_h, rd_en_h); end
      end
      if (rel_h == 131) begin
        n_assert++;
        if (wr_en_h !== 1'b1 || {wa_h, wb_h} !== (iv ? {8'd254, 8'd255} : {8'd127, 8'd255})) begin
          n_fail++; $display("FAIL haz_lastwr got en=%b %0d,%0d", wr_en_h, wa_h, wb_h);
        end
      end
      if (rel_h == 132) begin
        n_assert++;
        if (rd_en_h !== 1'b1 || {ra_h, rb_h, tw_h} !== (iv ? {8'd0, 8'd2, 8'd127} : {8'd0, 8'd64, 8'd2})) begin
          n_fail++; $display("FAIL haz_l1rd got en=%b %0d,%0d,%0d", rd_en_h, ra_h, rb_h, tw_h);
        end
      end
      if (sred_a === 1'b1) red_a++;
      if (sred_h === 1'b1) red_h++;
      tick(1'b0, iv, 1'b0);
    end
    n_assert++;
    if (red_a != 128 || red_h != 128) begin
      n_fail++; $display("FAIL sel_red_count got a=%0d h=%0d want 128", red_a, red_h);
    end
  endtask

  task automatic test_start_ignored();
    int n_rd;
    n_rd = 0;
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 1052; i++) begin
      n_assert++;
      if (got_a !== exp_a) begin n_fail++; $display("FAIL ign_a rel=%0d got=%h want=%h", rel_a, got_a, exp_a); end
      n_assert++;
      if (got_h !== exp_h) begin n_fail++; $display("FAIL ign_h rel=%0d got=%h want=%h", rel_h, got_h, exp_h); end
      if (rd_en_a === 1'b1) n_rd++;
      if (rel_a == 300) tick(1'b1, 1'b1, 1'b0);
      else if (rel_a < 1000) tick($urandom_range(0, 31) == 0, $urandom_range(0, 1) != 0, 1'b0);
      else tick(1'b0, 1'b0, 1'b0);
    end
    n_assert++;
    if (n_rd != 1024) begin n_fail++; $display("FAIL ign_rd_count got=%0d want=1024", n_rd); end
  endtask

  task automatic test_reset_mid();
    int n_wr;
    n_wr = 0;
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 500; i++) begin
      n_assert++;
      if (got_a !== exp_a) begin n_fail++; $display("FAIL rst_pre_a cyc=%0d got=%h want=%h", cyc, got_a, exp_a); end
      n_assert++;
      if (got_h !== exp_h) begin n_fail++; $display("FAIL rst_pre_h cyc=%0d got=%h want=%h", cyc, got_h, exp_h); end
      tick(1'b0, 1'b0, i == 500);
    end
    n_assert++;
    if (raw_a !== '0 || raw_h !== '0) begin
      n_fail++; $display("FAIL rst_mid_zero got_a=%h got_h=%h want=0", raw_a, raw_h);
    end
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (wr_en_a === 1'b1 || wr_en_h === 1'b1 || busy_a === 1'b1 || busy_h === 1'b1) n_wr++;
    end
    n_assert++;
    if (n_wr != 0) begin n_fail++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", n_wr); end
    tick(1'b1, 1'b0, 1'b0);
    n_assert++;
    if (rd_en_a !== 1'b1 || {ra_a, rb_a, tw_a} !== {8'd0, 8'd128, 8'd1} ||
        rd_en_h !== 1'b1 || {ra_h, rb_h, tw_h} !== {8'd0, 8'd128, 8'd1}) begin
      n_fail++; $display("FAIL rst_restart got a=%0d,%0d,%0d h=%0d,%0d,%0d want 0,128,1",
                         ra_a, rb_a, tw_a, ra_h, rb_h, tw_h);
    end
    for (int i = 0; i < 1052; i++) begin
      n_assert++;
      if (got_a !== exp_a) begin n_fail++; $display("FAIL rst_post_a rel=%0d got=%h want=%h", rel_a, got_a, exp_a); end
      n_assert++;
      if (got_h !== exp_h) begin n_fail++; $display("FAIL rst_post_h rel=%0d got=%h want=%h", rel_h, got_h, exp_h); end
      tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    bit iv1, iv2;
    int c1, c2;
    iv1 = ($urandom_range(0, 1) != 0);
    iv2 = ($urandom_range(0, 1) != 0);
    c1 = cyc + last_wr(D_A) + 2;
    c2 = cyc + last_wr(D_H) + 2;
    tick(1'b1, iv1, 1'b0);
    while (cyc < c2 + 1052) begin
      n_assert++;
      if (got_a !== exp_a) begin n_fail++; $display("FAIL b2b_a cyc=%0d got=%h want=%h", cyc, got_a, exp_a); end
      n_assert++;
      if (got_h !== exp_h) begin n_fail++; $display("FAIL b2b_h cyc=%0d got=%h want=%h", cyc, got_h, exp_h); end
      if (cyc == c1 + 1 || cyc == c2 + 1) begin
        n_assert++;
        if ((cyc == c1 + 1 ? {rd_en_a, ra_a, rb_a, tw_a} : {rd_en_h, ra_h, rb_h, tw_h}) !==
            {1'b1, 8'd0, (iv2 ? 8'd1 : 8'd128), (iv2 ? 8'd255 : 8'd1)}) begin
          n_fail++; $display("FAIL b2b_restart cyc=%0d got a=%b/%0d h=%b/%0d", cyc, rd_en_a, rb_a, rd_en_h, rb_h);
        end
      end
      tick(cyc == c1 || cyc == c2, iv2, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      int gap;
      gap = $urandom_range(0, 20);
      for (int i = 0; i < gap; i++) tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, $urandom_range(0, 1) != 0, 1'b0);
      for (int i = 0; i < 1100; i++) begin
        n_assert++;
        if (got_a !== exp_a) begin n_fail++; $display("FAIL rnd_a cyc=%0d got=%h want=%h", cyc, got_a, exp_a); end
        n_assert++;
        if (got_h !== exp_h) begin n_fail++; $display("FAIL rnd_h cyc=%0d got=%h want=%h", cyc, got_h, exp_h); end
        tick($urandom_range(0, 63) == 0, $urandom_range(0, 1) != 0, 1'b0);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; inv_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_forward();
    test_inverse();
    test_hazard();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
